// File: rtl/axi_sram_wr_ctrl.sv
// axi_sram_wr_ctrl: AXI write-channel slave sequencing single-port SRAM writes, one burst at a time
// Ports: aclk/aresetn (synchronous, active-low); AXI AW (awid..awvalid/awready), W (wdata, wstrb,
//   wlast, wvalid/wready) and B (bid, bresp, bvalid/bready); registered SRAM write port mem_*.
// Option: define AXI_WR_LAST_CHK_EN to flag wlast/beat-count mismatches as SLVERR.
module axi_sram_wr_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int ID_WIDTH     = 12,
  parameter int STROBE_WIDTH = DATA_WIDTH >> 3
) (
  input  logic                                       aclk,
  input  logic                                       aresetn,
  input  logic [ID_WIDTH-1:0]                        awid,
  input  logic [ADDR_WIDTH-1:0]                      awaddr,
  input  logic [7:0]                                 awlen,
  input  logic [2:0]                                 awsize,
  input  logic [1:0]                                 awburst,
  input  logic                                       awvalid,
  output logic                                       awready,
  input  logic [DATA_WIDTH-1:0]                      wdata,
  input  logic [STROBE_WIDTH-1:0]                    wstrb,
  input  logic                                       wlast,
  input  logic                                       wvalid,
  output logic                                       wready,
  output logic [ID_WIDTH-1:0]                        bid,
  output logic [1:0]                                 bresp,
  output logic                                       bvalid,
  input  logic                                       bready,
  output logic                                       mem_we,
  output logic [ADDR_WIDTH-$clog2(STROBE_WIDTH)-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]                      mem_wdata,
  output logic [STROBE_WIDTH-1:0]                    mem_be
);
  localparam int OFF = $clog2(STROBE_WIDTH);
  localparam int MAW = ADDR_WIDTH - OFF;
  localparam logic [ADDR_WIDTH-1:0] LANE = ADDR_WIDTH'(STROBE_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;
  state_t state_q, state_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d, we_q, we_d;
  logic err_q, err_d, size_err_q, size_err_d;
  logic [1:0] bresp_q, bresp_d, burst_q, burst_d;
  logic [2:0] size_q, size_d;
  logic [7:0] len_q, len_d, cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, lower_q, lower_d, upper_q, upper_d;
  logic [MAW-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STROBE_WIDTH-1:0] be_q, be_d, mask;
  logic [ADDR_WIDTH-1:0] a_total, a_lower, bytes, aligned, wrap_n, next_addr, lo, hi;
  logic wrap_ok, a_as_incr, a_size_err, last, beat;
  assign wrap_ok    = awlen == 8'd1 || awlen == 8'd3 || awlen == 8'd7 || awlen == 8'd15;
  // reserved bursts and illegal wrap lengths are walked as INCR but still reported
  assign a_as_incr  = awburst == 2'b11 || (awburst == 2'b10 && !wrap_ok);
  assign a_size_err = awsize > 3'(OFF);
  // wrap regions are only used for legal lengths, where the region size is a power of two
  assign a_total    = ADDR_WIDTH'((32'(awlen) + 32'd1) << awsize);
  assign a_lower    = awaddr & ~(a_total - ADDR_WIDTH'(1));
  assign bytes      = ADDR_WIDTH'(1) << size_q;
  assign aligned    = addr_q & ~(bytes - ADDR_WIDTH'(1));
  assign wrap_n     = addr_q + bytes;
  assign next_addr  = burst_q == 2'b00 ? addr_q :
                      burst_q == 2'b10 ? (wrap_n == upper_q ? lower_q : wrap_n) : aligned + bytes;
  assign lo         = addr_q & LANE;
  assign hi         = (aligned + bytes - ADDR_WIDTH'(1)) & LANE;
  assign last       = cnt_q == len_q;
  assign beat       = wvalid && wready_q;
  for (genvar i = 0; i < STROBE_WIDTH; i++) begin : g_lane
    assign mask[i] = ADDR_WIDTH'(i) >= lo && ADDR_WIDTH'(i) <= hi;
  end
`ifndef AXI_WR_LAST_CHK_EN
  logic unused_wlast;
  assign unused_wlast = wlast;
`endif
  always_comb begin
    state_d = state_q; awready_d = awready_q; wready_d = wready_q; bvalid_d = bvalid_q;
    bresp_d = bresp_q; bid_d = bid_q; we_d = 1'b0; maddr_d = maddr_q; wdata_d = wdata_q; be_d = be_q;
    addr_d = addr_q; lower_d = lower_q; upper_d = upper_q; len_d = len_q; size_d = size_q;
    burst_d = burst_q; cnt_d = cnt_q; err_d = err_q; size_err_d = size_err_q;
    case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          state_d = DATA; awready_d = 1'b0; wready_d = 1'b1;
          bid_d = awid; addr_d = awaddr; len_d = awlen; size_d = awsize; cnt_d = 8'd0;
          burst_d = a_as_incr ? 2'b01 : awburst;
          lower_d = a_lower; upper_d = a_lower + a_total;
          size_err_d = a_size_err;
          err_d = a_size_err || a_as_incr;
        end
      end
      DATA: if (beat) begin
        we_d = !size_err_q;
        maddr_d = MAW'(addr_q >> OFF);
        wdata_d = wdata;
        be_d = wstrb & mask;
        addr_d = next_addr;
        cnt_d = cnt_q + 8'd1;
`ifdef AXI_WR_LAST_CHK_EN
        err_d = err_q || (wlast != last);
`endif
        if (last) begin
          state_d = RESP; wready_d = 1'b0; bvalid_d = 1'b1;
          bresp_d = err_d ? 2'b10 : 2'b00;
        end
      end
      RESP: if (bready) begin
        state_d = IDLE; bvalid_d = 1'b0; awready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE; awready_q <= 1'b0; wready_q <= 1'b0; bvalid_q <= 1'b0; bresp_q <= '0;
      bid_q <= '0; we_q <= 1'b0; maddr_q <= '0; wdata_q <= '0; be_q <= '0; addr_q <= '0;
      lower_q <= '0; upper_q <= '0; len_q <= '0; size_q <= '0; burst_q <= '0; cnt_q <= '0;
      err_q <= 1'b0; size_err_q <= 1'b0;
    end else begin
      state_q <= state_d; awready_q <= awready_d; wready_q <= wready_d; bvalid_q <= bvalid_d;
      bresp_q <= bresp_d; bid_q <= bid_d; we_q <= we_d; maddr_q <= maddr_d; wdata_q <= wdata_d;
      be_q <= be_d; addr_q <= addr_d; lower_q <= lower_d; upper_q <= upper_d; len_q <= len_d;
      size_q <= size_d; burst_q <= burst_d; cnt_q <= cnt_d; err_q <= err_d; size_err_q <= size_err_d;
    end
  end
  assign awready   = awready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bresp     = bresp_q;
  assign bid       = bid_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
endmodule

// File: tb/tb_axi_sram_wr_ctrl.sv
// tb_axi_sram_wr_ctrl: scoreboard bench for axi_sram_wr_ctrl
module tb_axi_sram_wr_ctrl;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [11:0] awid = '0;
  logic [15:0] awaddr = '0;
  logic [7:0] awlen = '0;
  logic [2:0] awsize = '0;
  logic [1:0] awburst = '0;
  logic awvalid = 1'b0, awready;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic wlast = 1'b0, wvalid = 1'b0, wready;
  logic [11:0] bid;
  logic [1:0] bresp;
  logic bvalid, bready = 1'b0;
  logic mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_be;
  int total = 0, passed = 0;
  typedef struct { logic [13:0] a; logic [3:0] be; logic [31:0] d; } wr_t;
  typedef struct { logic [11:0] id; logic [1:0] r; } b_t;
  wr_t wq[$];
  b_t bq[$];
  always #5 aclk = ~aclk;
  axi_sram_wr_ctrl dut (
    .aclk(aclk), .aresetn(aresetn), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else passed++;
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  function automatic logic [15:0] beat_addr(input logic [15:0] a, input int n, input int size, input int len, input logic [1:0] eb);
    int ai, bytes, tot, al, lw;
    ai = int'(a); bytes = 1 << size; tot = bytes * (len + 1);
    al = (ai / bytes) * bytes; lw = (ai / tot) * tot;
    if (n == 0 || eb == 2'd0) return a;
    if (eb == 2'd2) return 16'(lw + ((al - lw + n * bytes) % tot));
    return 16'(al + n * bytes);
  endfunction
  function automatic logic [3:0] lane(input logic [15:0] a, input int size);
    int ai, bytes, al;
    logic [3:0] m;
    m = '0; ai = int'(a); bytes = 1 << size; al = (ai / bytes) * bytes;
    for (int b = ai; b < al + bytes; b++) m[b % 4] = 1'b1;
    return m;
  endfunction
  always @(negedge aclk) begin
    wr_t e;
    b_t b;
    if (mem_we) begin
      if (wq.size() == 0) chk("unexpected_we", 64'(mem_we), 64'd0);
      else begin
        e = wq.pop_front();
        chk("mem_addr", 64'(mem_addr), 64'(e.a));
        chk("mem_be", 64'(mem_be), 64'(e.be));
        chk("mem_wdata", 64'(mem_wdata), 64'(e.d));
      end
    end
    if (bvalid && bready) begin
      if (bq.size() == 0) chk("unexpected_b", 64'(bvalid), 64'd0);
      else begin
        b = bq.pop_front();
        chk("bid", 64'(bid), 64'(b.id));
        chk("bresp", 64'(bresp), 64'(b.r));
      end
    end
  end
  task automatic rst_chk();
    chk("rst_awready", 64'(awready), 0); chk("rst_wready", 64'(wready), 0);
    chk("rst_bvalid", 64'(bvalid), 0); chk("rst_bresp", 64'(bresp), 0);
    chk("rst_bid", 64'(bid), 0); chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_mem_addr", 64'(mem_addr), 0); chk("rst_mem_wdata", 64'(mem_wdata), 0);
    chk("rst_mem_be", 64'(mem_be), 0);
  endtask
  task automatic aw_send(input logic [11:0] id, input logic [15:0] a, input int len, input int size, input logic [1:0] bt);
    int n;
    n = 0;
    awid = id; awaddr = a; awlen = 8'(len); awsize = 3'(size); awburst = bt; awvalid = 1'b1;
    while (!awready && n < 20) begin step(); n++; end
    if (n == 20) chk("aw_timeout", 64'(awready), 1);
    step();
    awvalid = 1'b0;
  endtask
  task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
    int n;
    n = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (!wready && n < 20) begin step(); n++; end
    if (n == 20) chk("w_timeout", 64'(wready), 1);
    step();
    wvalid = 1'b0;
  endtask
  task automatic wait_b();
    int n;
    n = 0;
    bready = 1'b1;
    while (bq.size() != 0 && n < 50) begin step(); n++; end
    if (bq.size() != 0) chk("b_timeout", 64'(bq.size()), 0);
    bready = 1'b0;
  endtask
  task automatic burst(input logic [11:0] id, input logic [15:0] a, input int len, input int size, input logic [1:0] bt, input bit rs, input int hold);
    int n;
    bit bad_wrap, err;
    logic [1:0] eb;
    logic [15:0] ba;
    logic [31:0] d;
    logic [3:0] s;
    wr_t e;
    b_t b;
    bad_wrap = bt == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15);
    err = size > 2 || bt == 2'd3 || bad_wrap;
    eb = (bt == 2'd3 || bad_wrap) ? 2'd1 : bt;
    b.id = id; b.r = err ? 2'b10 : 2'b00;
    bq.push_back(b);
    aw_send(id, a, len, size, bt);
    for (int k = 0; k <= len; k++) begin
      ba = beat_addr(a, k, size, len, eb);
      d = $urandom;
      s = rs ? 4'($urandom) : 4'hF;
      if (size <= 2) begin
        e.a = ba[15:2]; e.be = s & lane(ba, size); e.d = d;
        wq.push_back(e);
      end
      w_send(d, s, k == len);
    end
    if (hold > 0) begin
      n = 0;
      while (!bvalid && n < 20) begin step(); n++; end
      for (int k = 0; k < hold; k++) begin
        chk("hold_bvalid", 64'(bvalid), 1); chk("hold_bid", 64'(bid), 64'(id));
        chk("hold_bresp", 64'(bresp), 64'(b.r)); chk("hold_awready", 64'(awready), 0);
        step();
      end
    end
    wait_b();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] ba;
    logic [31:0] d;
    wr_t e;
    repeat (3) step();
    rst_chk();
    aresetn = 1'b1;
    chk("awready_at_release", 64'(awready), 0);
    step();
    chk("awready_after_release", 64'(awready), 1);
    burst(12'h0A5, 16'h0003, 3, 0, 2'b01, 0, 0);
    burst(12'h123, 16'h0034, 3, 2, 2'b10, 0, 0);
    burst(12'h456, 16'h0002, 1, 2, 2'b01, 0, 0);
    burst(12'h789, 16'h0010, 2, 2, 2'b00, 0, 0);
    burst(12'hABC, 16'h0020, 1, 3, 2'b01, 0, 5);
    burst(12'h111, 16'h0040, 1, 2, 2'b11, 0, 0);
    burst(12'h222, 16'h0080, 2, 2, 2'b10, 0, 0);
    burst(12'h333, 16'h0101, 2, 1, 2'b01, 1, 0);
    burst(12'h444, 16'hFFFC, 1, 2, 2'b01, 0, 0);
    burst(12'h555, 16'h0108, 7, 2, 2'b10, 1, 0);
    aw_send(12'h077, 16'h0200, 7, 2, 2'b01);
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      ba = 16'h0200 + 16'(4 * k);
      e.a = ba[15:2]; e.be = 4'hF; e.d = d;
      wq.push_back(e);
      w_send(d, 4'hF, 1'b0);
    end
    aresetn = 1'b0;
    wdata = $urandom; wstrb = 4'hF; wvalid = 1'b1;
    step();
    rst_chk();
    wvalid = 1'b0;
    step();
    chk("no_b_after_reset", 64'(bvalid), 0);
    aresetn = 1'b1;
    chk("awready_at_rerelease", 64'(awready), 0);
    step();
    chk("awready_after_rerelease", 64'(awready), 1);
    chk("no_b_after_rerelease", 64'(bvalid), 0);
    burst(12'h0AB, 16'h0300, 1, 2, 2'b01, 0, 0);
    step();
    chk("wq_empty", 64'(wq.size()), 0);
    chk("bq_empty", 64'(bq.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/axi_sram_wr_ctrl.md
Name: axi_sram_wr_ctrl

Overview:
AXI write-channel slave controller that sequences single-port SRAM writes for one burst at a time. Accepts an AW request and walks it beat by beat, generating the per-beat address and byte-lane mask for FIXED, INCR and WRAP bursts. Drives the SRAM write port, then returns the B response. Sits between the AXI interconnect and the SRAM model in the SRAM subsystem.

Parameters:
DATA_WIDTH, 32, AXI/SRAM data width in bits (power of 2, >= 8)
ADDR_WIDTH, 16, AXI byte-address width
ID_WIDTH, 12, AWID/BID width
STROBE_WIDTH, DATA_WIDTH>>3, bytes per data word (derived; do not override)

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
awid  in  ID_WIDTH  write ID
awaddr  in  ADDR_WIDTH  start byte address
awlen  in  8  beats minus 1
awsize  in  3  log2 bytes per beat
awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
awvalid  in  1  AW valid
awready  out  1  AW ready
wdata  in  DATA_WIDTH  write data
wstrb  in  STROBE_WIDTH  write strobes
wlast  in  1  last beat marker
wvalid  in  1  W valid
wready  out  1  W ready
bid  out  ID_WIDTH  response ID
bresp  out  2  00 OKAY, 10 SLVERR
bvalid  out  1  B valid
bready  in  1  B ready
mem_we  out  1  SRAM write enable, one-cycle pulse per beat
mem_addr  out  ADDR_WIDTH-log2(STROBE_WIDTH)  SRAM word address
mem_wdata  out  DATA_WIDTH  SRAM write data
mem_be  out  STROBE_WIDTH  SRAM byte enables

Behaviour:
- Clock aclk; reset aresetn is synchronous and active-low. All outputs registered.
- Reset values: awready=0, wready=0, bvalid=0, bresp=00, bid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0; FSM=IDLE, beat_cnt=0, err=0.
- Reset asserted mid-burst: next edge forces reset values. The burst is discarded, no B is issued, and remaining W beats are not accepted.
- FSM IDLE: awready=1 (first asserted the cycle after reset release), wready=0.
  - On awvalid&&awready: latch id, addr, len, size, burst; beat_cnt=0; go DATA with awready=0.
- Boundaries computed at AW accept:
  - bytes = 1<<awsize.
  - lower_wrap = (awaddr/(bytes*(awlen+1)))*(bytes*(awlen+1)).
  - upper_wrap = lower_wrap + bytes*(awlen+1).
- Errors latched at AW accept (err=1 => bresp=10):
  - awsize > log2(STROBE_WIDTH): all mem_we suppressed; W beats still consumed.
  - awburst=11: treated as INCR.
  - WRAP with awlen not in {1,3,7,15}: treated as INCR.
- FSM DATA: wready=1.
  - Each wvalid&&wready beat at cur_addr produces, on the next edge (1-cycle latency):
    - mem_we=1 (0 if size error).
    - mem_addr = cur_addr>>log2(STROBE_WIDTH).
    - mem_wdata = wdata.
    - mem_be = wstrb & lane_mask.
  - Lane mask: bits lower..upper set, where lower = cur_addr mod STROBE_WIDTH and upper = ((cur_addr/bytes)*bytes + bytes-1) mod STROBE_WIDTH.
  - mem_we is deasserted in cycles with no beat.
  - Next address:
    - FIXED: unchanged.
    - INCR: (cur_addr/bytes)*bytes + bytes, modulo 2^ADDR_WIDTH. No 4KB boundary check.
    - WRAP: cur_addr+bytes; if the result equals upper_wrap, use lower_wrap.
  - Beat with beat_cnt==len: wready drops on the next edge; go RESP. Otherwise beat_cnt++.
- FSM RESP: bvalid=1, bid=latched id, bresp=err?10:00.
  - Held stable until bready.
  - On bvalid&&bready: bvalid=0, awready=1, go IDLE.
  - A new AW is never accepted while bvalid=1.
- Throughput: one beat per cycle in DATA; minimum burst turnaround = len+1 beats + 1 RESP cycle + 1 IDLE cycle.

Optional Feature:
AXI_WR_LAST_CHK_EN
- Defined: each beat compares wlast with (beat_cnt==len). A mismatch sets err (sticky for the burst) and the burst returns SLVERR. The burst still terminates on beat count, and writes are not suppressed.
- Undefined: wlast is ignored.

Test Plan:
- INCR awaddr=0x0003, awsize=0, awlen=3, wstrb=1111 -> mem_addr 0,1,1,1; mem_be 1000,0001,0010,0100; bresp=00, bid=awid.
- WRAP awaddr=0x0034, awsize=2, awlen=3 -> byte addrs 0x34,0x38,0x3C,0x30; mem_addr 0x0D,0x0E,0x0F,0x0C; mem_be=1111 each; bresp=00.
- Unaligned INCR awaddr=0x0002, awsize=2, awlen=1, wstrb=1111 -> beat0 mem_addr 0, mem_be 1100; beat1 mem_addr 1, mem_be 1111.
- FIXED awaddr=0x0010, awsize=2, awlen=2 -> mem_addr 4 on all 3 beats.
- awsize=3, awlen=1 -> two W beats accepted, mem_we never asserted, bresp=10. bready held low 5 cycles -> bvalid/bid/bresp stable, awready=0 throughout.
- INCR awlen=7, aresetn low after beat 2 -> next cycle all outputs at reset values, no bvalid. After release, awready=1 one cycle later and a new burst completes with bresp=00.
